collision_monitor: RTL and testbench

Per-frame collision and lives controller that drives the 2-bit SR command of the game-over latch: it issues a one-cycle set (SR=10) when the last life is lost and a one-cycle reset (SR=01) when a debounced start press restarts the game. It sits between the asteroid field/ship position logic (upstream) and the game-over SR flip-flop (downstream). It also applies a post-hit invulnerability window.

---
 rtl/collision_monitor_if.sv | 57 +++++
 rtl/collision_monitor.sv | 216 +++++++++++++++++++++
 tb/tb_collision_monitor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/collision_monitor_if.sv
// ---------------------------------------------------------------------------
// collision_monitor_if
//
// Bundles the frame-level signals exchanged between the playfield logic, the
// start key and the collision/lives controller.
//
//   tick          frame-advance strobe (one cycle)
//   ship_col      ship column in the bottom row
//   asteroid_row  bottom-row asteroid occupancy, bit i = column i
//   start_btn     raw, asynchronous, bouncing start key (active-high)
//   SR            game-over latch command: 00 hold, 10 set, 01 reset
//   hit           one-cycle pulse per life-costing collision
//   lives         remaining lives
//   invuln        high while the post-hit grace window is active
//
// Modports:
//   master  drives the playfield/start inputs and observes the results
//   slave   the controller side (collision_monitor)
// ---------------------------------------------------------------------------
interface collision_monitor_if #(
  parameter int COLS  = 16,
  parameter int LIVES = 3
);
  localparam int COL_W   = $clog2(COLS);
  localparam int LIVES_W = $clog2(LIVES + 1);

  logic                tick;
  logic [COL_W-1:0]    ship_col;
  logic [COLS-1:0]     asteroid_row;
  logic                start_btn;
  logic [1:0]          SR;
  logic                hit;
  logic [LIVES_W-1:0]  lives;
  logic                invuln;

  modport master (
    output tick,
    output ship_col,
    output asteroid_row,
    output start_btn,
    input  SR,
    input  hit,
    input  lives,
    input  invuln
  );

  modport slave (
    input  tick,
    input  ship_col,
    input  asteroid_row,
    input  start_btn,
    output SR,
    output hit,
    output lives,
    output invuln
  );
endinterface

// File: rtl/collision_monitor.sv
// ---------------------------------------------------------------------------
// collision_monitor
//
// Per-frame collision and lives controller. On each frame tick in PLAY the
// bottom-row asteroid bit under the ship is examined; a collision costs a
// life and opens a grace window of GRACE_TICKS ticks, or, on the last life,
// issues a one-cycle SET (SR=10) to the downstream game-over latch. While the
// game is over, a debounced start press issues a one-cycle RESET (SR=01) and
// refills the lives.
//
// Ports:
//   CLK   system clock
//   RST   synchronous, active-high reset
//   bus   collision_monitor_if.slave
//           in : tick, ship_col, asteroid_row, start_btn
//           out: SR, hit, lives, invuln (all registered)
// ---------------------------------------------------------------------------
module collision_monitor #(
  parameter int COLS        = 16,
  parameter int LIVES       = 3,
  parameter int GRACE_TICKS = 2,
  parameter int DEBOUNCE    = 50000
) (
  input  logic                  CLK,
  input  logic                  RST,
  collision_monitor_if.slave    bus
);

  localparam int COL_W   = $clog2(COLS);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int GRACE_W = $clog2(GRACE_TICKS + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE + 1);

  localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_NONE = LIVES_W'(0);
  localparam logic [GRACE_W-1:0] GRACE_LOAD = GRACE_W'(GRACE_TICKS);
  localparam logic [GRACE_W-1:0] GRACE_ONE  = GRACE_W'(1);
  localparam logic [GRACE_W-1:0] GRACE_NONE = GRACE_W'(0);
  // The counter clears on the same edge that it would reach DEBOUNCE, so the
  // last increment is from DEBOUNCE-1.
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE - 1);
  localparam logic [DEB_W-1:0]   DEB_NONE   = DEB_W'(0);
  localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_SET   = 2'b10;
  localparam logic [1:0] SR_RESET = 2'b01;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_GRACE = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // Bit of the bottom row under the ship.
  function automatic logic occupied(input logic [COLS-1:0] row,
                                    input logic [COL_W-1:0] col);
    return row[col];
  endfunction

  // -------------------------------------------------------------------------
  // Start key: synchronizer, debouncer, rising-edge press detect
  // -------------------------------------------------------------------------
  logic              sync1_r;
  logic              sync2_r;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic              deb_r;
  logic              deb_prev_r;
  logic              press_s;

  // Two-flop synchronizer for the asynchronous start key.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= bus.start_btn;
      sync2_r <= sync1_r;
    end
  end

  // Debouncer: the level follows the synchronized key only after it has
  // disagreed for DEBOUNCE consecutive cycles; any agreement restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      deb_cnt_r  <= DEB_NONE;
      deb_r      <= 1'b0;
      deb_prev_r <= 1'b0;
    end else begin
      deb_prev_r <= deb_r;
      if (sync2_r != deb_r) begin
        if (deb_cnt_r == DEB_LAST) begin
          deb_r     <= sync2_r;
          deb_cnt_r <= DEB_NONE;
        end else begin
          deb_cnt_r <= deb_cnt_r + DEB_ONE;
        end
      end else begin
        deb_cnt_r <= DEB_NONE;
      end
    end
  end

  // A press is a single-cycle pulse on the debounced rising edge, so a held
  // key produces one press and presses outside OVER simply vanish.
  assign press_s = deb_r & ~deb_prev_r;

  // -------------------------------------------------------------------------
  // Lives / game FSM
  // -------------------------------------------------------------------------
  state_t              state_r;
  state_t              state_next;
  logic [LIVES_W-1:0]  lives_r;
  logic [LIVES_W-1:0]  lives_next;
  logic [GRACE_W-1:0]  grace_r;
  logic [GRACE_W-1:0]  grace_next;
  logic [1:0]          sr_r;
  logic [1:0]          sr_next;
  logic                hit_r;
  logic                hit_next;
  logic                invuln_r;
  logic                invuln_next;
  logic                collision_s;

  assign collision_s = occupied(bus.asteroid_row, bus.ship_col);

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= ST_PLAY;
      lives_r  <= LIVES_FULL;
      grace_r  <= GRACE_NONE;
      sr_r     <= SR_HOLD;
      hit_r    <= 1'b0;
      invuln_r <= 1'b0;
    end else begin
      state_r  <= state_next;
      lives_r  <= lives_next;
      grace_r  <= grace_next;
      sr_r     <= sr_next;
      hit_r    <= hit_next;
      invuln_r <= invuln_next;
    end
  end

  // Next-state and next-output decode. SR and hit default to idle so any
  // command lasts exactly one cycle.
  always_comb begin
    state_next = state_r;
    lives_next = lives_r;
    grace_next = grace_r;
    sr_next    = SR_HOLD;
    hit_next   = 1'b0;

    case (state_r)
      ST_PLAY: begin
        if (bus.tick && collision_s) begin
          hit_next = 1'b1;
          if (lives_r > LIVES_ONE) begin
            lives_next = lives_r - LIVES_ONE;
            grace_next = GRACE_LOAD;
            state_next = ST_GRACE;
          end else begin
            lives_next = LIVES_NONE;
            sr_next    = SR_SET;
            state_next = ST_OVER;
          end
        end else begin
          state_next = ST_PLAY;
        end
      end

      ST_GRACE: begin
        // Ticks only count down the window; collisions are not examined.
        if (bus.tick) begin
          grace_next = grace_r - GRACE_ONE;
          if (grace_r == GRACE_ONE) begin
            state_next = ST_PLAY;
          end else begin
            state_next = ST_GRACE;
          end
        end else begin
          state_next = ST_GRACE;
        end
      end

      ST_OVER: begin
        // A press takes priority over a coincident tick; the tick is dropped.
        if (press_s) begin
          sr_next    = SR_RESET;
          lives_next = LIVES_FULL;
          grace_next = GRACE_NONE;
          state_next = ST_PLAY;
        end else begin
          lives_next = LIVES_NONE;
          state_next = ST_OVER;
        end
      end

      default: begin
        state_next = ST_PLAY;
        lives_next = LIVES_FULL;
        grace_next = GRACE_NONE;
      end
    endcase

    invuln_next = (state_next == ST_GRACE);
  end

  assign bus.SR     = sr_r;
  assign bus.hit    = hit_r;
  assign bus.lives  = lives_r;
  assign bus.invuln = invuln_r;

endmodule

// File: tb/tb_collision_monitor.sv
// ---------------------------------------------------------------------------
// tb_collision_monitor
//
// Directed bench for collision_monitor with COLS=16, LIVES=3, GRACE_TICKS=2,
// DEBOUNCE=4. Inputs change on the falling edge; outputs are sampled 1 time
// unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_collision_monitor;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  collision_monitor_if #(.COLS(16), .LIVES(3)) bus ();

  collision_monitor #(
    .COLS(16),
    .LIVES(3),
    .GRACE_TICKS(2),
    .DEBOUNCE(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle tick with the given bottom row; returns just after the edge
  // that sampled it.
  task automatic do_tick(input logic [15:0] row);
    @(negedge CLK);
    bus.asteroid_row = row;
    bus.tick = 1'b1;
    @(posedge CLK);
    #1;
    bus.tick = 1'b0;
  endtask

  initial begin
    RST              = 1'b1;
    bus.tick         = 1'b0;
    bus.ship_col     = 4'd0;
    bus.asteroid_row = 16'h0000;
    bus.start_btn    = 1'b0;

    // 1. Reset
    repeat (2) @(posedge CLK);
    #1;
    check("rst_sr",     bus.SR,     2'b00);
    check("rst_lives",  bus.lives,  2'd3);
    check("rst_hit",    bus.hit,    1'b0);
    check("rst_invuln", bus.invuln, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    // 2. Near miss then hit
    bus.ship_col = 4'd5;
    do_tick(16'hFFDF);
    check("miss_hit",   bus.hit,   1'b0);
    check("miss_lives", bus.lives, 2'd3);
    do_tick(16'h0020);
    check("hit1_hit",    bus.hit,    1'b1);
    check("hit1_lives",  bus.lives,  2'd2);
    check("hit1_invuln", bus.invuln, 1'b1);
    step();
    check("hit1_pulse", bus.hit, 1'b0);

    // 3. Grace window
    do_tick(16'h0020);
    check("grace1_lives",  bus.lives,  2'd2);
    check("grace1_invuln", bus.invuln, 1'b1);
    check("grace1_hit",    bus.hit,    1'b0);
    do_tick(16'h0020);
    check("grace2_lives",  bus.lives,  2'd2);
    check("grace2_invuln", bus.invuln, 1'b0);
    check("grace2_hit",    bus.hit,    1'b0);
    do_tick(16'h0020);
    check("hit2_lives",  bus.lives,  2'd1);
    check("hit2_hit",    bus.hit,    1'b1);
    check("hit2_invuln", bus.invuln, 1'b1);

    // 4. Fatal hit (first leave the second grace window)
    do_tick(16'h0020);
    do_tick(16'h0020);
    check("grace_exit_invuln", bus.invuln, 1'b0);
    check("grace_exit_lives",  bus.lives,  2'd1);
    do_tick(16'h0020);
    check("fatal_sr",     bus.SR,     2'b10);
    check("fatal_lives",  bus.lives,  2'd0);
    check("fatal_hit",    bus.hit,    1'b1);
    check("fatal_invuln", bus.invuln, 1'b0);
    step();
    check("fatal_sr_off", bus.SR,  2'b00);
    check("fatal_hit_off", bus.hit, 1'b0);
    for (int i = 0; i < 2; i++) begin
      do_tick(16'h0020);
      check("over_tick_hit",   bus.hit,   1'b0);
      check("over_tick_sr",    bus.SR,    2'b00);
      check("over_tick_lives", bus.lives, 2'd0);
    end

    // 5. Bouncy restart: two cycles high, two low, for 12 cycles
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      bus.start_btn = ((i % 4) < 2);
      step();
      check("bounce_sr", bus.SR, 2'b00);
    end
    // Hold: SR=01 after the 7th edge of the hold
    @(negedge CLK);
    bus.start_btn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge CLK);
      #1;
      check("hold_wait_sr", bus.SR, 2'b00);
      if (e == 6) begin
        // Colliding tick on the same edge as the press: the press wins.
        @(negedge CLK);
        bus.asteroid_row = 16'h0020;
        bus.tick = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
    bus.tick = 1'b0;
    check("restart_sr",     bus.SR,     2'b01);
    check("restart_lives",  bus.lives,  2'd3);
    check("restart_hit",    bus.hit,    1'b0);
    check("restart_invuln", bus.invuln, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_no_repeat_sr", bus.SR, 2'b00);
    end
    check("hold_lives", bus.lives, 2'd3);
    // Release, then press again while in PLAY
    @(negedge CLK);
    bus.start_btn = 1'b0;
    repeat (10) step();
    @(negedge CLK);
    bus.start_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("play_press_sr", bus.SR, 2'b00);
    end
    check("play_press_lives",  bus.lives,  2'd3);
    check("play_press_invuln", bus.invuln, 1'b0);
    @(negedge CLK);
    bus.start_btn = 1'b0;

    // 6. Reset mid-GRACE with grace counter at 1
    do_tick(16'h0020);
    check("pre_rst_lives", bus.lives, 2'd2);
    do_tick(16'h0000);
    check("pre_rst_invuln", bus.invuln, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    step();
    check("midrst_lives",  bus.lives,  2'd3);
    check("midrst_invuln", bus.invuln, 1'b0);
    check("midrst_sr",     bus.SR,     2'b00);
    check("midrst_hit",    bus.hit,    1'b0);
    @(negedge CLK);
    RST = 1'b0;
    do_tick(16'h0020);
    check("post_rst_lives", bus.lives, 2'd2);
    check("post_rst_hit",   bus.hit,   1'b1);
    step();
    check("post_rst_sr", bus.SR, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
